// File: rtl/ad9980_cfg_sequencer.sv
// ---------------------------------------------------------------------------
// ad9980_cfg_sequencer
//
// Table-driven configuration scheduler for the AD9980 video digitizer.
// On Start it walks a 27-entry register table (18 common entries followed by
// 9 entries chosen by the latched video Mode) and hands each addr:data pair
// to a single-byte I2C write engine over a req/done handshake. After the first
// write it waits SETTLE_CYCLES clocks so the part can power up. A NACKed write
// is re-issued up to MAX_RETRY times before the sequence aborts.
//
// Optional build macro: AD9980_MODE_AUTO_EN
//   When defined, Mode is double-flop synchronized. A stable Mode change
//   seen while in DONE re-runs only the mode-specific entries 18-26, without
//   the settle delay. Mode=3 there ends in ERROR with Err_index=6'h3F.
//
// Ports
//   Clk, Reset_n      : clock, asynchronous active-low reset
//   Start             : one-cycle pulse, launches a full sequence
//   Mode[1:0]         : 0=VGA, 1=SVGA, 2=XGA, 3=reserved
//   Wr_req            : write request to the I2C engine
//   Wr_slave[6:0]     : slave address, always SLAVE_ADDR
//   Wr_addr/Wr_data   : register address / data, stable while Wr_req is high
//   Wr_done, Wr_nack  : engine completion pulse and its NACK qualifier
//   Busy, Done, Error : sequence status (Done and Error are sticky)
//   Err_index[5:0]    : failing table index, 6'h3F for reserved Mode
// ---------------------------------------------------------------------------
module ad9980_cfg_sequencer #(
  parameter logic [6:0] SLAVE_ADDR    = 7'h4C,
  parameter int         MAX_RETRY     = 3,
  parameter int         SETTLE_CYCLES = 2000,
  parameter int         CNT_W         = 16
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       Start,
  input  logic [1:0] Mode,
  output logic       Wr_req,
  output logic [6:0] Wr_slave,
  output logic [7:0] Wr_addr,
  output logic [7:0] Wr_data,
  input  logic       Wr_done,
  input  logic       Wr_nack,
  output logic       Busy,
  output logic       Done,
  output logic       Error,
  output logic [5:0] Err_index
);

  localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [RETRY_W-1:0] RETRY_LAST  = RETRY_W'(MAX_RETRY);
  localparam logic [CNT_W-1:0]   SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [4:0]         LAST_INDEX  = 5'd26;
  localparam logic [4:0]         MODE_BASE   = 5'd18;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_REQ    = 3'd2,
    ST_SETTLE = 3'd3,
    ST_NEXT   = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERROR  = 3'd6
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         mode_q, mode_d;
  logic [4:0]         index_q, index_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         addr_q, addr_d;
  logic [7:0]         data_q, data_d;
  logic [5:0]         err_index_q, err_index_d;
  logic               wr_req_q, wr_req_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               error_q, error_d;
  logic [15:0]        entry_s;

  // Register table lookup: returns {addr, data} for a mode and table index.
  function automatic logic [15:0] table_entry(input logic [1:0] mode, input logic [4:0] idx);
    logic [15:0] e;
    e = 16'h0000;
    if (idx < MODE_BASE) begin
      case (idx)
        5'd0:    e = 16'h1EA4;
        5'd1:    e = 16'h1F14;
        5'd2:    e = 16'h2001;
        5'd3:    e = 16'h0540;
        5'd4:    e = 16'h0600;
        5'd5:    e = 16'h0740;
        5'd6:    e = 16'h0800;
        5'd7:    e = 16'h0940;
        5'd8:    e = 16'h0A00;
        5'd9:    e = 16'h1B33;
        5'd10:   e = 16'h0B02;
        5'd11:   e = 16'h0C00;
        5'd12:   e = 16'h0D02;
        5'd13:   e = 16'h0E00;
        5'd14:   e = 16'h0F02;
        5'd15:   e = 16'h1000;
        5'd16:   e = 16'h1800;
        5'd17:   e = 16'h1280;
        default: e = 16'h0000;
      endcase
    end else begin
      // Address column is shared by all modes; only the data differs.
      case (idx)
        5'd18:   e = 16'h0100;
        5'd19:   e = 16'h0200;
        5'd20:   e = 16'h0300;
        5'd21:   e = 16'h0400;
        5'd22:   e = 16'h1200;
        5'd23:   e = 16'h1300;
        5'd24:   e = 16'h1400;
        5'd25:   e = 16'h1900;
        5'd26:   e = 16'h1A00;
        default: e = 16'h0000;
      endcase
      case (mode)
        2'd0: begin
          case (idx)
            5'd18:   e[7:0] = 8'h32;
            5'd19:   e[7:0] = 8'h00;
            5'd20:   e[7:0] = 8'h48;
            5'd21:   e[7:0] = 8'hA0;
            5'd22:   e[7:0] = 8'h10;
            5'd23:   e[7:0] = 8'h60;
            5'd24:   e[7:0] = 8'h10;
            5'd25:   e[7:0] = 8'h04;
            5'd26:   e[7:0] = 8'h1A;
            default: e[7:0] = 8'h00;
          endcase
        end
        2'd1: begin
          case (idx)
            5'd18:   e[7:0] = 8'h42;
            5'd19:   e[7:0] = 8'h00;
            5'd20:   e[7:0] = 8'h48;
            5'd21:   e[7:0] = 8'h80;
            5'd22:   e[7:0] = 8'h18;
            5'd23:   e[7:0] = 8'h80;
            5'd24:   e[7:0] = 8'h18;
            5'd25:   e[7:0] = 8'h04;
            5'd26:   e[7:0] = 8'h3C;
            default: e[7:0] = 8'h00;
          endcase
        end
        2'd2: begin
          case (idx)
            5'd18:   e[7:0] = 8'h54;
            5'd19:   e[7:0] = 8'h00;
            5'd20:   e[7:0] = 8'hA8;
            5'd21:   e[7:0] = 8'h80;
            5'd22:   e[7:0] = 8'h10;
            5'd23:   e[7:0] = 8'h88;
            5'd24:   e[7:0] = 8'h10;
            5'd25:   e[7:0] = 8'h04;
            5'd26:   e[7:0] = 8'h20;
            default: e[7:0] = 8'h00;
          endcase
        end
        default: e = 16'h0000;
      endcase
    end
    return e;
  endfunction

  assign entry_s = table_entry(mode_q, index_q);

`ifdef AD9980_MODE_AUTO_EN
  logic [1:0] mode_s1_q, mode_s2_q, mode_s3_q;
  logic       auto_hit_s;

  // Mode synchronizer plus one history stage for the 2-cycle stability check.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      mode_s1_q <= 2'd0;
      mode_s2_q <= 2'd0;
      mode_s3_q <= 2'd0;
    end else begin
      mode_s1_q <= Mode;
      mode_s2_q <= mode_s1_q;
      mode_s3_q <= mode_s2_q;
    end
  end

  assign auto_hit_s = (mode_s2_q != mode_q) && (mode_s2_q == mode_s3_q);
`endif

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    index_d     = index_q;
    retry_d     = retry_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    data_d      = data_q;
    err_index_d = err_index_q;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (Start) begin
          mode_d      = Mode;
          index_d     = 5'd0;
          retry_d     = {RETRY_W{1'b0}};
          err_index_d = 6'd0;
          if (Mode == 2'd3) begin
            err_index_d = 6'h3F;
            state_d     = ST_ERROR;
          end else begin
            state_d = ST_LOAD;
          end
        end
`ifdef AD9980_MODE_AUTO_EN
        else if ((state_q == ST_DONE) && auto_hit_s) begin
          mode_d      = mode_s2_q;
          retry_d     = {RETRY_W{1'b0}};
          err_index_d = 6'd0;
          if (mode_s2_q == 2'd3) begin
            err_index_d = 6'h3F;
            state_d     = ST_ERROR;
          end else begin
            // Partial run never passes through index 0, so no settle.
            index_d = MODE_BASE;
            state_d = ST_LOAD;
          end
        end
`endif
        else begin
          state_d = state_q;
        end
      end
      ST_LOAD: begin
        addr_d  = entry_s[15:8];
        data_d  = entry_s[7:0];
        state_d = ST_REQ;
      end
      ST_REQ: begin
        if (Wr_done) begin
          if (!Wr_nack) begin
            retry_d = {RETRY_W{1'b0}};
            cnt_d   = {CNT_W{1'b0}};
            if (index_q == 5'd0) begin
              state_d = ST_SETTLE;
            end else begin
              state_d = ST_NEXT;
            end
          end else if (retry_q < RETRY_LAST) begin
            retry_d = retry_q + {{(RETRY_W-1){1'b0}}, 1'b1};
            state_d = ST_LOAD;
          end else begin
            err_index_d = {1'b0, index_q};
            state_d     = ST_ERROR;
          end
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = ST_NEXT;
        end else begin
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_NEXT: begin
        if (index_q == LAST_INDEX) begin
          state_d = ST_DONE;
        end else begin
          index_d = index_q + 5'd1;
          state_d = ST_LOAD;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are registered copies of the state being entered.
    wr_req_d = (state_d == ST_REQ);
    busy_d   = (state_d == ST_LOAD) || (state_d == ST_REQ) ||
               (state_d == ST_SETTLE) || (state_d == ST_NEXT);
    done_d   = (state_d == ST_DONE);
    error_d  = (state_d == ST_ERROR);
  end

  // State, datapath and output registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= ST_IDLE;
      mode_q      <= 2'd0;
      index_q     <= 5'd0;
      retry_q     <= {RETRY_W{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
      addr_q      <= 8'h00;
      data_q      <= 8'h00;
      err_index_q <= 6'd0;
      wr_req_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      index_q     <= index_d;
      retry_q     <= retry_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      err_index_q <= err_index_d;
      wr_req_q    <= wr_req_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign Wr_req    = wr_req_q;
  assign Wr_slave  = SLAVE_ADDR;
  assign Wr_addr   = addr_q;
  assign Wr_data   = data_q;
  assign Busy      = busy_q;
  assign Done      = done_q;
  assign Error     = error_q;
  assign Err_index = err_index_q;

endmodule
